// File: rtl/pwm_shadow_core.sv
// pwm_shadow_core: single-channel PWM generator with double-buffered settings.
// A load strobe stages period/duty/polarity. The staged values move into the
// shadow registers when the channel starts or at a period boundary, so a period
// that is already running is never disturbed.
//
// Ports:
//   clk, rst_n   clock (posedge) and asynchronous active-low reset
//   en           channel enable; sampled when idle and at each period boundary
//   polarity     0: active-high output, 1: active-low output (staged by load)
//   period       PWM period minus one (staged by load)
//   duty_cycle   active cycles per period (staged by load)
//   load         one-cycle strobe that captures period/duty_cycle/polarity
//   out          registered PWM output
//   busy         high while running
//   period_done  one-cycle pulse on the last cycle of each period
//   cnt          registered position within the current period
module pwm_shadow_core #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 polarity,
    input  logic [CNT_WIDTH-1:0] period,
    input  logic [CNT_WIDTH-1:0] duty_cycle,
    input  logic                 load,
    output logic                 out,
    output logic                 busy,
    output logic                 period_done,
    output logic [CNT_WIDTH-1:0] cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [CNT_WIDTH-1:0] per;
        logic [CNT_WIDTH-1:0] duty;
        logic                 pol;
    } cfg_t;

    state_t               state_q, state_d;
    cfg_t                 stage_q, stage_d;
    cfg_t                 shadow_q, shadow_d;
    cfg_t                 cfg_in;
    logic                 pend_q, pend_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 out_q, out_d;
    logic                 busy_q, busy_d;
    logic                 pd_q, pd_d;
    logic                 xfer;
    logic                 run_d;

    // State, settings and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            stage_q  <= '0;
            shadow_q <= '0;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
            out_q    <= 1'b0;
            busy_q   <= 1'b0;
            pd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            pd_q     <= pd_d;
        end
    end

    // Next state, staging/transfer, and next values of the registered outputs.
    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        xfer     = 1'b0;

        cfg_in.per  = period;
        cfg_in.duty = duty_cycle;
        cfg_in.pol  = polarity;

        if (load) begin
            stage_d = cfg_in;
            pend_d  = 1'b1;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en) begin
                    state_d = RUN;
                    xfer    = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q == shadow_q.per) begin
                    // Period boundary: the only point where en is honoured.
                    cnt_d = '0;
                    xfer  = 1'b1;
                    if (!en) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A load landing on a transfer cycle bypasses the stage.
        if (xfer) begin
            if (load) begin
                shadow_d = cfg_in;
            end else if (pend_q) begin
                shadow_d = stage_q;
            end
            pend_d = 1'b0;
        end

        // Outputs are computed from next-cycle values so they line up with cnt.
        run_d  = (state_d == RUN);
        busy_d = run_d;
        out_d  = run_d ? ((cnt_d < shadow_d.duty) ^ shadow_d.pol) : shadow_d.pol;
        pd_d   = run_d && (cnt_d == shadow_d.per);
    end

    assign out         = out_q;
    assign busy        = busy_q;
    assign period_done = pd_q;
    assign cnt         = cnt_q;

endmodule

// File: tb/tb_pwm_shadow_core.sv
// Directed bench for pwm_shadow_core: reset, staging/transfer timing,
// duty/period extremes, polarity, and enable handling at period boundaries.
module tb_pwm_shadow_core;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        polarity;
    logic [15:0] period;
    logic [15:0] duty_cycle;
    logic        load;
    logic        out;
    logic        busy;
    logic        period_done;
    logic [15:0] cnt;

    int n_cmp = 0;
    int n_err = 0;

    pwm_shadow_core #(.CNT_WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .polarity    (polarity),
        .period      (period),
        .duty_cycle  (duty_cycle),
        .load        (load),
        .out         (out),
        .busy        (busy),
        .period_done (period_done),
        .cnt         (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One running cycle: counter, output, period_done and busy.
    task automatic exp_run(input string tag, input int c, input bit o, input bit pd);
        chk($sformatf("%s.cnt%0d", tag, c), 32'(cnt), 32'(c));
        chk($sformatf("%s.out%0d", tag, c), 32'(out), 32'(o));
        chk($sformatf("%s.pd%0d", tag, c), 32'(period_done), 32'(pd));
        chk($sformatf("%s.busy%0d", tag, c), 32'(busy), 32'd1);
    endtask

    // Idle/reset view of all outputs.
    task automatic exp_idle(input string tag, input bit o);
        chk($sformatf("%s.cnt", tag), 32'(cnt), 32'd0);
        chk($sformatf("%s.out", tag), 32'(out), 32'(o));
        chk($sformatf("%s.pd", tag), 32'(period_done), 32'd0);
        chk($sformatf("%s.busy", tag), 32'(busy), 32'd0);
    endtask

    // Checks a full period=4 period starting at observed cnt=0; pat[k] = out at cnt k.
    // Leaves the bench observing cnt=0 of the following period.
    task automatic chk_period(input string tag, input logic [4:0] pat);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            exp_run(tag, k, pat[k], (k == 4));
        end
        tick();
    endtask

    // Runs to the last cycle of the current period and loads on that cycle.
    task automatic load_at_boundary(input string tag, input logic [15:0] p,
                                    input logic [15:0] d, input bit pl);
        int n;
        n = 0;
        while (period_done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk($sformatf("%s.boundary", tag), 32'(period_done), 32'd1);
        period     = p;
        duty_cycle = d;
        polarity   = pl;
        load       = 1'b1;
        tick();
        load       = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        polarity   = 1'b0;
        period     = 16'd0;
        duty_cycle = 16'd0;
        load       = 1'b0;

        // T1: reset values, then enable with nothing loaded.
        tick();
        tick();
        exp_idle("t1_reset", 1'b0);
        rst_n = 1'b1;
        en    = 1'b1;
        tick();
        exp_run("t1_noload", 0, 1'b0, 1'b1);
        tick();
        exp_run("t1_noload", 0, 1'b0, 1'b1);
        en = 1'b0;
        tick();
        exp_idle("t1_idle", 1'b0);

        // T2: load while idle, start, two periods of 1,1,0,0,0.
        period     = 16'd4;
        duty_cycle = 16'd2;
        polarity   = 1'b0;
        load       = 1'b1;
        tick();
        load = 1'b0;
        exp_idle("t2_staged", 1'b0);
        en = 1'b1;
        tick();
        chk_period("t2a", 5'b00011);
        chk_period("t2b", 5'b00011);

        // T3: load duty=4 at cnt=1; current period unchanged, next is 1,1,1,1,0.
        exp_run("t3", 0, 1'b1, 1'b0);
        tick();
        exp_run("t3", 1, 1'b1, 1'b0);
        duty_cycle = 16'd4;
        load       = 1'b1;
        tick();
        load = 1'b0;
        exp_run("t3", 2, 1'b0, 1'b0);
        tick();
        exp_run("t3", 3, 1'b0, 1'b0);
        tick();
        exp_run("t3", 4, 1'b0, 1'b1);
        tick();
        chk_period("t3new", 5'b01111);

        // T4: loads of duty=1 then duty=3 in one period; the last one wins.
        duty_cycle = 16'd1;
        load       = 1'b1;
        tick();
        load = 1'b0;
        exp_run("t4", 1, 1'b1, 1'b0);
        tick();
        exp_run("t4", 2, 1'b1, 1'b0);
        duty_cycle = 16'd3;
        load       = 1'b1;
        tick();
        load = 1'b0;
        exp_run("t4", 3, 1'b1, 1'b0);
        tick();
        exp_run("t4", 4, 1'b0, 1'b1);
        tick();
        chk_period("t4last", 5'b00111);
        // Load on the cnt==4 cycle applies to the very next period.
        load_at_boundary("t4b", 16'd4, 16'd2, 1'b0);
        chk_period("t4b", 5'b00011);

        // T5: extremes.
        load_at_boundary("t5d0", 16'd4, 16'd0, 1'b0);
        chk_period("t5d0", 5'b00000);
        load_at_boundary("t5d6", 16'd4, 16'd6, 1'b0);
        chk_period("t5d6", 5'b11111);
        load_at_boundary("t5pol", 16'd4, 16'd2, 1'b1);
        chk_period("t5pol", 5'b11100);
        load_at_boundary("t5p0", 16'd0, 16'd1, 1'b0);
        exp_run("t5p0", 0, 1'b1, 1'b1);
        tick();
        exp_run("t5p0", 0, 1'b1, 1'b1);
        tick();
        exp_run("t5p0", 0, 1'b1, 1'b1);

        // T6: en dropped at cnt=2 finishes the period, then idles at pol level.
        load_at_boundary("t6", 16'd4, 16'd2, 1'b1);
        exp_run("t6", 0, 1'b0, 1'b0);
        tick();
        exp_run("t6", 1, 1'b0, 1'b0);
        tick();
        exp_run("t6", 2, 1'b1, 1'b0);
        en = 1'b0;
        tick();
        exp_run("t6", 3, 1'b1, 1'b0);
        tick();
        exp_run("t6", 4, 1'b1, 1'b1);
        tick();
        exp_idle("t6_idle", 1'b1);
        tick();
        exp_idle("t6_idle2", 1'b1);
        // en toggled off and back on inside a period: no gap.
        en = 1'b1;
        tick();
        exp_run("t6tog", 0, 1'b0, 1'b0);
        en = 1'b0;
        tick();
        exp_run("t6tog", 1, 1'b0, 1'b0);
        en = 1'b1;
        tick();
        exp_run("t6tog", 2, 1'b1, 1'b0);
        tick();
        exp_run("t6tog", 3, 1'b1, 1'b0);
        tick();
        exp_run("t6tog", 4, 1'b1, 1'b1);
        tick();
        exp_run("t6cont", 0, 1'b0, 1'b0);
        tick();
        exp_run("t6cont", 1, 1'b0, 1'b0);

        // T1 mid-run: stage a load, then reset asynchronously; the stage is lost.
        period     = 16'd4;
        duty_cycle = 16'd5;
        polarity   = 1'b0;
        load       = 1'b1;
        tick();
        load = 1'b0;
        exp_run("t1_pre", 2, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        exp_idle("t1_async", 1'b0);
        tick();
        exp_idle("t1_held", 1'b0);
        rst_n = 1'b1;
        en    = 1'b0;
        tick();
        exp_idle("t1_rel", 1'b0);
        en = 1'b1;
        tick();
        exp_run("t1_restart", 0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
